// File: rtl/fp32_to_fp16_pipe.sv
// Streaming FP32 -> FP16 narrowing converter: round-to-nearest-even, IEEE exception flags,
// two registered stages (classify/align, then round/pack) with valid/ready on both sides.
module fp32_to_fp16_pipe (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_data,
  output logic [3:0]  out_flags
);

  typedef struct packed {
    logic        sign;
    logic        special;     // result fully decided in stage 1 (NaN, inf, zero, overflow, denorm)
    logic [14:0] spec_mag;
    logic [3:0]  spec_flags;
    logic [4:0]  exp;
    logic [9:0]  mant;
    logic        guard;
    logic        sticky;
    logic        tiny;
  } s1_t;

  logic        r_s1_valid;
  s1_t         r_s1;
  logic        r_out_valid;
  logic [15:0] r_out_data;
  logic [3:0]  r_out_flags;

  logic        w_s2_adv;
  logic        w_sign;
  logic [7:0]  w_e;
  logic [22:0] w_m;
  logic [7:0]  w_dsh;
  logic [33:0] w_pre;
  logic [33:0] w_ext;
  s1_t         w_s1;

  logic        w_round_up;
  logic        w_inexact;
  logic [14:0] w_sum;
  logic [15:0] w_res_data;
  logic [3:0]  w_res_flags;

  assign w_s2_adv  = !r_out_valid || out_ready;
  assign in_ready  = !r_s1_valid || w_s2_adv;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_flags = r_out_flags;

  // Stage 1: unpack and classify. For tiny results the shift is sh = -E-1 = 126-e; the
  // hidden-one significand is pre-aligned by the minimum shift of 14, so w_dsh = sh-14.
  assign w_sign = in_data[31];
  assign w_e    = in_data[30:23];
  assign w_m    = in_data[22:0];
  assign w_dsh  = 8'd112 - w_e;
  assign w_pre  = {1'b1, w_m, 10'b0};
  assign w_ext  = w_pre >> w_dsh;

  always_comb begin
    w_s1      = '0;
    w_s1.sign = w_sign;
    if (w_e == 8'hFF) begin
      w_s1.special = 1'b1;
      if (w_m != 23'd0) begin
        w_s1.spec_mag   = {5'h1F, 1'b1, w_m[21:13]};
        w_s1.spec_flags = {~w_m[22], 3'b000};
      end else begin
        w_s1.spec_mag = 15'h7C00;
      end
    end else if (w_e == 8'h00) begin
      w_s1.special    = 1'b1;
      w_s1.spec_flags = (w_m != 23'd0) ? 4'b0011 : 4'b0000;
    end else if (w_e >= 8'd143) begin
      w_s1.special    = 1'b1;
      w_s1.spec_mag   = 15'h7C00;
      w_s1.spec_flags = 4'b0101;
    end else if (w_e >= 8'd113) begin
      // Rebias e-127+15 = e-112; mod 32 that is e[4:0]+16.
      w_s1.exp    = w_e[4:0] + 5'd16;
      w_s1.mant   = w_m[22:13];
      w_s1.guard  = w_m[12];
      w_s1.sticky = |w_m[11:0];
    end else begin
      w_s1.tiny = 1'b1;
      if (w_dsh > 8'd10) begin
        w_s1.sticky = 1'b1;
      end else begin
        w_s1.mant   = w_ext[33:24];
        w_s1.guard  = w_ext[23];
        w_s1.sticky = |w_ext[22:0];
      end
    end
  end

  // Stage 2: round-to-nearest-even on the packed {exp, mant}; carry ripples into the exponent.
  assign w_round_up = r_s1.guard && (r_s1.sticky || r_s1.mant[0]);
  assign w_inexact  = r_s1.guard || r_s1.sticky;
  assign w_sum      = {r_s1.exp, r_s1.mant} + {14'd0, w_round_up};

  always_comb begin
    w_res_data  = {r_s1.sign, w_sum};
    w_res_flags = {2'b00, r_s1.tiny && w_inexact, w_inexact};
    if (r_s1.special) begin
      w_res_data  = {r_s1.sign, r_s1.spec_mag};
      w_res_flags = r_s1.spec_flags;
    end else if (w_sum[14:10] == 5'h1F) begin
      w_res_data  = {r_s1.sign, 15'h7C00};
      w_res_flags = 4'b0101;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_valid  <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_data  <= 16'h0000;
      r_out_flags <= 4'h0;
    end else begin
      if (in_ready) begin
        r_s1_valid <= in_valid;
      end
      if (w_s2_adv) begin
        r_out_valid <= r_s1_valid;
        if (r_s1_valid) begin
          r_out_data  <= w_res_data;
          r_out_flags <= w_res_flags;
        end
      end
    end
  end

  // NOTE: the stage-1 payload has no reset; r_s1_valid alone qualifies it, so a stale value is never observed.
  always_ff @(posedge clk) begin
    if (in_valid && in_ready) begin
      r_s1 <= w_s1;
    end
  end

endmodule
